// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM behind a posted write buffer.
// Processor side: MemAddr/WriteData/MemWrite/MemRead in, MemData (comb),
//   MemStall (buffer full) out.
// Host side: HostEn/HostWrite/HostAddr/HostWData in, HostRData/HostValid
//   (registered, one cycle after HostEn) out; host owns the array port.
// Status: WbCount = write-buffer occupancy.
// Optional: define DMEM_MISALIGN_TRAP_EN to add a sticky AlignErr output;
//   misaligned stores are dropped and misaligned loads return 32'hDEADBEEF.
module dmem_responder #(
    parameter int WORDS    = 1024,
    parameter int WB_DEPTH = 4
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [15:0]                 MemAddr,
    input  logic [31:0]                 WriteData,
    input  logic                        MemWrite,
    input  logic                        MemRead,
    output logic [31:0]                 MemData,
    output logic                        MemStall,
    input  logic                        HostEn,
    input  logic                        HostWrite,
    input  logic [15:0]                 HostAddr,
    input  logic [31:0]                 HostWData,
    output logic [31:0]                 HostRData,
    output logic                        HostValid,
    output logic [$clog2(WB_DEPTH):0]   WbCount
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic                        AlignErr
`endif
);

    localparam int AW = $clog2(WORDS);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW:0] PTR_ONE = 1;

    // Storage
    logic [31:0]   mem     [WORDS];
    logic [AW-1:0] wb_idx  [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PW:0] head;
    logic [PW:0] tail;

    logic [AW-1:0] mem_idx;
    logic [AW-1:0] host_idx;
    logic          empty;
    logic          full;
    logic          misalign;
    logic          push;
    logic          drain;

    logic          arr_we;
    logic [AW-1:0] arr_waddr;
    logic [31:0]   arr_wdata;

    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] slot;

    // Address bits above the array depth alias; they are deliberately unused
    logic unused_addr;
    assign unused_addr = ^{MemAddr, HostAddr};

    assign mem_idx  = MemAddr[AW+1:2];
    assign host_idx = HostAddr[AW+1:2];

    assign empty = (head == tail);
    assign full  = (head[PW] != tail[PW]) &&
                   (head[PW-1:0] == tail[PW-1:0]);

    assign WbCount = tail - head;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (MemAddr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Full is judged on the pre-edge state, so a drain in the same
    // cycle does not free a slot for this store
    assign MemStall = MemWrite && full;
    assign push     = MemWrite && !full && !misalign;
    assign drain    = !empty && !HostEn;

    // Buffer pointers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (drain) begin
                head <= head + PTR_ONE;
            end
        end
    end

    // Buffer payload; stale slots are harmless once pointers are cleared
    always_ff @(posedge Clock) begin
        if (push) begin
            wb_idx[tail[PW-1:0]]  <= mem_idx;
            wb_data[tail[PW-1:0]] <= WriteData;
        end
    end

    // Single array write port: host wins, otherwise the buffer head drains
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = wb_idx[head[PW-1:0]];
        arr_wdata = wb_data[head[PW-1:0]];
        if (!Reset) begin
            if (HostEn) begin
                arr_we    = HostWrite;
                arr_waddr = host_idx;
                arr_wdata = HostWData;
            end else if (!empty) begin
                arr_we = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (arr_we) begin
            mem[arr_waddr] <= arr_wdata;
        end
    end

    // Host read path
    always_ff @(posedge Clock) begin
        if (Reset) begin
            HostRData <= '0;
            HostValid <= 1'b0;
        end else begin
            HostValid <= HostEn && !HostWrite;
            if (HostEn && !HostWrite) begin
                HostRData <= mem[host_idx];
            end
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head[PW-1:0] + PW'(i);
            if ((CW'(i) < WbCount) && (wb_idx[slot] == mem_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[slot];
            end
        end
    end

    // Processor load data
    always_comb begin
        MemData = '0;
        if (MemRead) begin
            if (misalign) begin
                MemData = 32'hDEADBEEF;
            end else if (fwd_hit) begin
                MemData = fwd_data;
            end else begin
                MemData = mem[mem_idx];
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            AlignErr <= 1'b0;
        end else if ((MemRead || MemWrite) && misalign) begin
            AlignErr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks of dmem_responder
// against a queue-based behavioural model of the memory and write buffer.
module tb_dmem_responder;

    localparam int WORDS    = 1024;
    localparam int WB_DEPTH = 4;
    localparam int CW       = $clog2(WB_DEPTH) + 1;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [15:0]   MemAddr;
    logic [31:0]   WriteData;
    logic          MemWrite;
    logic          MemRead;
    logic [31:0]   MemData;
    logic          MemStall;
    logic          HostEn;
    logic          HostWrite;
    logic [15:0]   HostAddr;
    logic [31:0]   HostWData;
    logic [31:0]   HostRData;
    logic          HostValid;
    logic [CW-1:0] WbCount;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic          AlignErr;
`endif

    dmem_responder #(.WORDS(WORDS), .WB_DEPTH(WB_DEPTH)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .MemAddr(MemAddr),
        .WriteData(WriteData),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .MemData(MemData),
        .MemStall(MemStall),
        .HostEn(HostEn),
        .HostWrite(HostWrite),
        .HostAddr(HostAddr),
        .HostWData(HostWData),
        .HostRData(HostRData),
        .HostValid(HostValid),
`ifdef DMEM_MISALIGN_TRAP_EN
        .AlignErr(AlignErr),
`endif
        .WbCount(WbCount)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: array + FIFO queue of pending stores
    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } ent_t;

    logic [31:0] mdl_mem [WORDS];
    ent_t        wbq [$];
    logic [31:0] m_hrd;
    logic        m_hv;
    logic        m_ae;

    function automatic int unsigned widx(input logic [15:0] a);
        return (int'(a) / 4) % WORDS;
    endfunction

    function automatic bit is_misal();
`ifdef DMEM_MISALIGN_TRAP_EN
        return (MemAddr % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_mem_data();
        int unsigned a;
        if (!MemRead) return 32'h0;
        if (is_misal()) return 32'hDEADBEEF;
        a = widx(MemAddr);
        for (int i = wbq.size() - 1; i >= 0; i--) begin
            if (wbq[i].idx == a) return wbq[i].data;
        end
        return mdl_mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied
    task automatic model_edge();
        bit   full_b;
        bit   mis;
        ent_t e;
        if (Reset) begin
            wbq.delete();
            m_hrd = 32'h0;
            m_hv  = 1'b0;
            m_ae  = 1'b0;
        end else begin
            full_b = (wbq.size() == WB_DEPTH);
            mis    = is_misal();
            if (HostEn && !HostWrite) m_hrd = mdl_mem[widx(HostAddr)];
            m_hv = HostEn && !HostWrite;
            if (!HostEn && wbq.size() > 0) begin
                e = wbq.pop_front();
                mdl_mem[e.idx] = e.data;
            end
            if (HostEn && HostWrite) mdl_mem[widx(HostAddr)] = HostWData;
            if (MemWrite && !full_b && !mis) begin
                e.idx  = widx(MemAddr);
                e.data = WriteData;
                wbq.push_back(e);
            end
            if ((MemRead || MemWrite) && mis) m_ae = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    // Per-cycle comparison against the model
    always @(negedge Clock) begin
        if (chk_en) begin
            check("mem_data", MemData, exp_mem_data());
            check("mem_stall", 32'(MemStall),
                  32'(MemWrite && wbq.size() == WB_DEPTH));
            check("wb_count", 32'(WbCount), 32'(wbq.size()));
            check("host_valid", 32'(HostValid), 32'(m_hv));
            check("host_rdata", HostRData, m_hrd);
`ifdef DMEM_MISALIGN_TRAP_EN
            check("align_err", 32'(AlignErr), 32'(m_ae));
`endif
        end
    end

    function automatic logic [15:0] rand_addr();
        logic [3:0] hi;
        logic [4:0] lo;
        hi = 4'($urandom);
        lo = 5'($urandom_range(0, 31));
        return {hi, 5'b0, lo, 2'b00};
    endfunction

    task automatic idle_inputs();
        MemAddr   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        HostEn    = 1'b0;
        HostWrite = 1'b0;
        HostAddr  = '0;
        HostWData = '0;
    endtask

    task automatic host_read_check(input logic [15:0] a, input logic [31:0] v,
                                   input string name);
        HostEn    = 1'b1;
        HostWrite = 1'b0;
        HostAddr  = a;
        tick();
        HostEn = 1'b0;
        @(negedge Clock);
        check({name, "_valid"}, 32'(HostValid), 32'd1);
        check(name, HostRData, v);
        tick();
    endtask

    initial begin
        int host_pct;
        idle_inputs();
        m_hrd = '0;
        m_hv  = 1'b0;
        m_ae  = 1'b0;
        Reset = 1'b1;
        tick();
        chk_en = 1'b1;
        @(negedge Clock);
        check("rst_wb_count", 32'(WbCount), 32'd0);
        check("rst_host_valid", 32'(HostValid), 32'd0);
        check("rst_host_rdata", HostRData, 32'd0);
        check("rst_mem_data", MemData, 32'd0);
        check("rst_mem_stall", 32'(MemStall), 32'd0);
        tick();
        Reset = 1'b0;

        // Preload the words used by all tests
        for (int i = 0; i < 32; i++) begin
            HostEn    = 1'b1;
            HostWrite = 1'b1;
            HostAddr  = 16'(i * 4);
            HostWData = $urandom;
            tick();
        end
        idle_inputs();

        // Host write then processor read
        HostEn = 1'b1; HostWrite = 1'b1;
        HostAddr = 16'h0010; HostWData = 32'h11111111;
        tick();
        idle_inputs();
        MemRead = 1'b1; MemAddr = 16'h0010;
        @(negedge Clock);
        check("t1_mem_data", MemData, 32'h11111111);
        check("t1_wb_count", 32'(WbCount), 32'd0);
        tick();

        // Store, forwarded load, drain, host read
        idle_inputs();
        MemWrite = 1'b1; MemAddr = 16'h0020; WriteData = 32'hA5A5A5A5;
        tick();
        MemWrite = 1'b0; MemRead = 1'b1;
        @(negedge Clock);
        check("t2_fwd", MemData, 32'hA5A5A5A5);
        tick();
        MemRead = 1'b0;
        tick();
        host_read_check(16'h0020, 32'hA5A5A5A5, "t2_host");

        // Youngest match wins
        HostEn = 1'b1; HostWrite = 1'b0; HostAddr = 16'h0010;
        MemWrite = 1'b1; MemAddr = 16'h0030; WriteData = 32'h1;
        tick();
        WriteData = 32'h2;
        tick();
        MemWrite = 1'b0; MemRead = 1'b1;
        @(negedge Clock);
        check("t3_youngest", MemData, 32'h2);
        check("t3_wb_count", 32'(WbCount), 32'd2);
        tick();
        idle_inputs();
        repeat (3) tick();

        // Fill to full, refused fifth store, then drain
        HostEn = 1'b1; HostWrite = 1'b0; HostAddr = 16'h0010;
        for (int k = 0; k < 5; k++) begin
            MemWrite  = 1'b1;
            MemAddr   = 16'(16'h0040 + 4 * k);
            WriteData = 32'(32'h100 + k);
            if (k == 4) begin
                @(negedge Clock);
                check("t4_stall", 32'(MemStall), 32'd1);
                check("t4_full_cnt", 32'(WbCount), 32'd4);
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            check("t4_drain_cnt", 32'(WbCount), 32'(4 - c));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            host_read_check(16'(16'h0040 + 4 * k), 32'(32'h100 + k), "t4_host");
        end

        // Reset discards buffered stores, array survives
        HostEn = 1'b1; HostWrite = 1'b1;
        HostAddr = 16'h0060; HostWData = 32'h60606060;
        tick();
        HostWrite = 1'b0; HostAddr = 16'h0010;
        for (int k = 1; k <= 3; k++) begin
            MemWrite = 1'b1; MemAddr = 16'h0060; WriteData = 32'(32'hC0DE0000 + k);
            tick();
        end
        idle_inputs();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        @(negedge Clock);
        check("t5_wb_count", 32'(WbCount), 32'd0);
        tick();
        host_read_check(16'h0060, 32'h60606060, "t5_host");

`ifdef DMEM_MISALIGN_TRAP_EN
        MemRead = 1'b1; MemAddr = 16'h0022;
        @(negedge Clock);
        check("t6_deadbeef", MemData, 32'hDEADBEEF);
        tick();
        MemRead = 1'b0;
        @(negedge Clock);
        check("t6_align_err", 32'(AlignErr), 32'd1);
        tick();
        MemWrite = 1'b1; MemAddr = 16'h0023; WriteData = 32'h12345678;
        tick();
        MemWrite = 1'b0;
        @(negedge Clock);
        check("t6_drop_cnt", 32'(WbCount), 32'd0);
        check("t6_sticky", 32'(AlignErr), 32'd1);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
`endif

        // Randomized traffic with bursts of heavy host use
        host_pct = 25;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) host_pct = ($urandom_range(0, 1) == 1) ? 85 : 20;
            MemAddr   = rand_addr();
            WriteData = $urandom;
            MemWrite  = ($urandom_range(0, 99) < 55);
            MemRead   = ($urandom_range(0, 99) < 50);
            HostEn    = ($urandom_range(0, 99) < host_pct);
            HostWrite = ($urandom_range(0, 1) == 1);
            HostAddr  = rand_addr();
            HostWData = $urandom;
            Reset     = ($urandom_range(0, 299) == 0);
            if (Reset) HostEn = 1'b0;
            tick();
        end
        idle_inputs();
        Reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the processor's MEM-stage interface (MemAddr, WriteData, MemWrite, MemRead in; MemData out).
- Word-addressed RAM array fronted by a posted write buffer. The buffer drains into the array one entry per cycle.
- Reads are answered combinationally in the same cycle, with forwarding from the write buffer.
- A host port (testbench loader/debug) shares the single array port and has priority over the drain.

Parameters:
- WORDS, 1024, array depth in 32-bit words (power of 2, max 16384).
- WB_DEPTH, 4, write-buffer entries (power of 2, >= 2).

Ports:
- Clock  input  1  system clock, rising-edge
- Reset  input  1  synchronous, active-high reset
- MemAddr  input  16  byte address from processor; word index = MemAddr[15:2]
- WriteData  input  32  processor store data
- MemWrite  input  1  processor store strobe
- MemRead  input  1  processor load strobe
- MemData  output  32  load data, combinational
- MemStall  output  1  write buffer full; processor must hold the store
- HostEn  input  1  host access request (single-cycle)
- HostWrite  input  1  1 = host write, 0 = host read
- HostAddr  input  16  host byte address
- HostWData  input  32  host write data
- HostRData  output  32  host read data, registered
- HostValid  output  1  HostRData valid, pulses 1 cycle
- WbCount  output  $clog2(WB_DEPTH)+1  current buffer occupancy

Behaviour:
- Reset values:
  - MemData = 0 (no read active), MemStall = 0, HostRData = 0, HostValid = 0, WbCount = 0.
  - Buffer pointers cleared; pending buffered writes are discarded.
  - Array contents are not cleared.
- Write buffer:
  - Circular FIFO with head/tail pointers one bit wider than the index; full/empty by MSB compare; pointers wrap modulo WB_DEPTH.
  - Entry = {word index, data}.
- Enqueue: MemWrite=1 and not full -> push at tail at the clock edge. MemWrite=1 while full -> store not accepted; MemStall=1 combinationally that cycle.
- Drain:
  - Each cycle with buffer non-empty and no HostEn, the head entry is written to the array and the head advances.
  - Enqueue and drain in the same cycle -> WbCount unchanged.
  - Enqueue into full buffer with simultaneous drain is still refused (full evaluated before the edge).
- Host priority:
  - HostEn=1 owns the array port that cycle; the drain is blocked.
  - Host write goes to the array directly. Host write does not search the buffer; stale buffered entries to the same word later overwrite it (by design).
  - Host read: HostRData = array[HostAddr[15:2]] registered; HostValid=1 on the next cycle.
- Processor reads: MemRead=1 -> MemData = youngest buffer entry whose index matches, else array[MemAddr[15:2]]. Same cycle, no latency.
- MemRead=0 -> MemData = 0.
- MemRead and MemWrite together: the read returns the pre-write value; the write enqueues.
- Index bits above log2(WORDS) are ignored (aliasing).
- Latency: store visible to the processor next cycle via forwarding; to the host after drain (at most WB_DEPTH cycles with no host traffic).

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output AlignErr (1 bit, reset 0), sticky until Reset.
  - Set when MemRead or MemWrite is active with MemAddr[1:0] != 0.
  - The offending store is dropped (not enqueued); the offending load returns 32'hDEADBEEF.
- Undefined: MemAddr[1:0] ignored; no AlignErr port.

Test Plan:
- Reset, then host writes 0x11111111 to addr 0x0010 -> processor MemRead at 0x0010 returns 0x11111111; WbCount=0.
- Processor stores 0xA5A5A5A5 to 0x0020, then loads 0x0020 next cycle -> MemData=0xA5A5A5A5 via forwarding. After drain, host read of 0x0020 -> HostRData=0xA5A5A5A5 with HostValid one cycle after HostEn.
- Two stores to 0x0030 (0x1, then 0x2) with HostEn held high -> MemRead 0x0030 returns 0x2 (youngest match wins); WbCount=2.
- HostEn held high, 5 consecutive stores with WB_DEPTH=4 -> 5th store sees MemStall=1 and is not accepted. Drop HostEn -> WbCount decrements 4->0 over 4 cycles; host reads show all 4 accepted values.
- 3 stores buffered (HostEn high), then Reset asserted one cycle -> WbCount=0; host read returns the prior array contents (buffered data lost).
- With DMEM_MISALIGN_TRAP_EN: MemRead at 0x0022 -> MemData=0xDEADBEEF and AlignErr=1, held until Reset. Store to 0x0023 -> WbCount unchanged.
